// File: rtl/sr_drive_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sr_drive_pkg
//  Desc     : Shared types and constants for the SR flop drive controller:
//             FSM state encoding, operation encodings, cycle-counter width.
//  Revision : 1.0 - initial release
// ============================================================================
package sr_drive_pkg;

    // Width of the shared pulse/timeout down-counter (covers 1..15 cycles)
    localparam int CNT_W = 4;

    // Operation encodings carried on req_op and held as the drive target
    localparam logic OP_SET = 1'b1;
    localparam logic OP_RST = 1'b0;

    // Controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

endpackage : sr_drive_pkg
`default_nettype wire

// File: rtl/sr_pulse_timer.sv
`default_nettype none
// ============================================================================
//  Module   : sr_pulse_timer
//  Desc     : Loadable down-counter with an expiry flag. Loading N makes the
//             flag rise after N further cycles, so a phase of N+1 cycles is
//             timed by loading N on entry and leaving when the flag is seen.
//  Revision : 1.0 - initial release
// ============================================================================
module sr_pulse_timer
    import sr_drive_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_cnt;

    // Load takes priority; otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule : sr_pulse_timer
`default_nettype wire

// File: rtl/sr_drive_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sr_drive_ctrl
//  Desc     : Drives set/reset pulses into a downstream SR flop on request.
//             A request whose target already matches qn_fb completes at once
//             without driving. Otherwise s or r is held for PULSE_W cycles.
//             With SR_DRIVE_VERIFY_EN defined, the controller then waits up
//             to TIMEOUT cycles for qn_fb to reach the target and signals
//             done or err; without it, completion follows the pulse directly.
//  Config   : `define SR_DRIVE_VERIFY_EN enables the CHECK phase and err.
//  Revision : 1.0 - initial release
// ============================================================================
module sr_drive_ctrl
    import sr_drive_pkg::*;
#(
    parameter int PULSE_W = 2,
    parameter int TIMEOUT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_op,
    output logic       req_ready,
    input  logic       qn_fb,
    output logic       s,
    output logic       r,
    output logic       done,
    output logic       err,
    output logic [7:0] op_cnt
);

    // Both timing parameters must fit the 4-bit counter and be non-zero
    if (PULSE_W < 1 || PULSE_W > 15) begin : g_bad_pulse_w
        $error("sr_drive_ctrl: PULSE_W must be in 1..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 15) begin : g_bad_timeout
        $error("sr_drive_ctrl: TIMEOUT must be in 1..15");
    end

    // Timer holds (phase length - 1) on entry so expiry marks the last cycle
    localparam logic [CNT_W-1:0] c_PULSE_LOAD = CNT_W'(PULSE_W - 1);
`ifdef SR_DRIVE_VERIFY_EN
    localparam logic [CNT_W-1:0] c_TIMEOUT_LOAD = CNT_W'(TIMEOUT - 1);
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_target;
    logic             r_done;
    logic             r_err;
    logic [7:0]       r_op_cnt;

    logic             w_accept;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_done_nxt;
    logic             w_err_nxt;
    logic             w_expired;

    assign req_ready = (r_state == IDLE);
    assign w_accept  = req_valid && req_ready;

    sr_pulse_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_expired  (w_expired)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, timer control and completion decode
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (qn_fb == req_op) begin
                        // Flop already holds the target: complete without driving
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = DRIVE;
                        w_load      = 1'b1;
                        w_load_val  = c_PULSE_LOAD;
                    end
                end
            end
            DRIVE: begin
                if (w_expired) begin
`ifdef SR_DRIVE_VERIFY_EN
                    w_state_nxt = CHECK;
                    w_load      = 1'b1;
                    w_load_val  = c_TIMEOUT_LOAD;
`else
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
`endif
                end
            end
            CHECK: begin
`ifdef SR_DRIVE_VERIFY_EN
                if (qn_fb == r_target) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else if (w_expired) begin
                    w_state_nxt = IDLE;
                    w_err_nxt   = 1'b1;
                end
`else
                // Unreachable without verification; recover to IDLE
                w_state_nxt = IDLE;
`endif
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Target latch, one-cycle status pulses and completion counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_target <= OP_RST;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_op_cnt <= 8'd0;
        end else begin
            if (w_accept) begin
                r_target <= req_op;
            end
            r_done <= w_done_nxt;
            r_err  <= w_err_nxt;
            if (w_done_nxt) begin
                r_op_cnt <= r_op_cnt + 8'd1;
            end
        end
    end

    // Drives are only ever active in DRIVE, and only one by construction
    assign s      = (r_state == DRIVE) && (r_target == OP_SET);
    assign r      = (r_state == DRIVE) && (r_target == OP_RST);
    assign done   = r_done;
    assign err    = r_err;
    assign op_cnt = r_op_cnt;

endmodule : sr_drive_ctrl
`default_nettype wire

// File: tb/tb_sr_drive_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sr_drive_ctrl
//  Desc     : Self-checking bench for sr_drive_ctrl. A timeline model derives
//             expected outputs from the accept time of each operation; a
//             simple downstream flop answers s/r pulses with a chosen delay.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sr_drive_ctrl;

    localparam int P = 2;
    localparam int T = 4;
`ifdef SR_DRIVE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_op = 1'b0;
    logic       req_ready;
    logic       qn_fb = 1'b0;
    logic       s;
    logic       r;
    logic       done;
    logic       err;
    logic [7:0] op_cnt;

    sr_drive_ctrl #(.PULSE_W(P), .TIMEOUT(T)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_ready (req_ready),
        .qn_fb     (qn_fb),
        .s         (s),
        .r         (r),
        .done      (done),
        .err       (err),
        .op_cnt    (op_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- timeline reference model ----------------
    bit m_valid = 1'b0;
    bit m_busy  = 1'b0;
    bit m_target = 1'b0;
    int m_cyc  = 0;
    int m_tacc = 0;
    bit e_s, e_r, e_done, e_err, e_ready;
    int e_cnt = 0;

    // Cycle k is the interval after edge k; an operation accepted in cycle a
    // drives in cycles a+1..a+P, then (verify) checks in a+P+1..a+P+T.
    always @(posedge clk) begin : model
        int d;
        m_cyc++;
        e_done = 1'b0;
        e_err  = 1'b0;
        if (rst) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            e_cnt   = 0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_target = req_op;
                if (qn_fb == req_op) begin
                    e_done = 1'b1;
                    e_cnt  = (e_cnt + 1) % 256;
                end else begin
                    m_busy = 1'b1;
                    m_tacc = m_cyc - 1;
                end
            end
        end else begin
            d = m_cyc - 1 - m_tacc;
            if (VERIFY) begin
                if (d > P) begin
                    if (qn_fb == m_target) begin
                        e_done = 1'b1;
                        e_cnt  = (e_cnt + 1) % 256;
                        m_busy = 1'b0;
                    end else if (d - P == T) begin
                        e_err  = 1'b1;
                        m_busy = 1'b0;
                    end
                end
            end else if (d == P) begin
                e_done = 1'b1;
                e_cnt  = (e_cnt + 1) % 256;
                m_busy = 1'b0;
            end
        end
        e_ready = !m_busy;
        e_s = m_busy && ((m_cyc - m_tacc) <= P) && m_target;
        e_r = m_busy && ((m_cyc - m_tacc) <= P) && !m_target;
    end

    // ---------------- per-cycle compare and observation ----------------
    int obs_s = 0, obs_r = 0, obs_done = 0, obs_err = 0, obs_both = 0;

    always @(negedge clk) begin
        if (m_valid) begin
            chk("s",         32'(s),         32'(e_s));
            chk("r",         32'(r),         32'(e_r));
            chk("done",      32'(done),      32'(e_done));
            chk("err",       32'(err),       32'(e_err));
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("op_cnt",    32'(op_cnt),    32'(e_cnt));
            if (s === 1'b1) obs_s++;
            if (r === 1'b1) obs_r++;
            if (done === 1'b1) obs_done++;
            if (err === 1'b1) obs_err++;
            if (s === 1'b1 && r === 1'b1) obs_both++;
        end
    end

    task automatic clear_obs();
        obs_s = 0; obs_r = 0; obs_done = 0; obs_err = 0; obs_both = 0;
    endtask

    // ---------------- downstream flop stand-in ----------------
    int p_cyc = 0;
    int p_at = 0;
    int p_lat = 1;
    bit p_stuck = 1'b0;
    bit p_rand = 1'b0;
    bit p_pend = 1'b0;
    bit p_val = 1'b0;
    bit p_s_prev = 1'b0;
    bit p_r_prev = 1'b0;

    task automatic step();
        bit rise;
        @(posedge clk);
        #1;
        p_cyc++;
        rise = 1'b0;
        if (s === 1'b1 && !p_s_prev) begin p_val = 1'b1; rise = 1'b1; end
        if (r === 1'b1 && !p_r_prev) begin p_val = 1'b0; rise = 1'b1; end
        if (rise) begin
            if (p_rand) begin
                p_lat   = $urandom_range(0, 7);
                p_stuck = ($urandom_range(0, 3) == 0);
            end
            p_at   = p_cyc + p_lat;
            p_pend = !p_stuck;
        end
        p_s_prev = (s === 1'b1);
        p_r_prev = (r === 1'b1);
        if (p_pend && p_cyc >= p_at) begin
            qn_fb  = p_val;
            p_pend = 1'b0;
        end
    endtask

    task automatic force_qn(input bit v);
        qn_fb  = v;
        p_pend = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int accepted;
        int guard;
        bit nxt;

        // Reset
        rst = 1'b1; req_valid = 1'b0; force_qn(1'b0);
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("reset_ready",  32'(req_ready), 32'd1);
        chk("reset_op_cnt", 32'(op_cnt),    32'd0);
        chk("reset_drives", 32'({s, r, done, err}), 32'd0);

        // Set with qn_fb=0, flop answers one cycle into the pulse
        clear_obs();
        p_lat = 1; p_stuck = 1'b0;
        req_valid = 1'b1; req_op = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (12) step();
        chk("set_s_cycles", 32'(obs_s),    32'd2);
        chk("set_r_cycles", 32'(obs_r),    32'd0);
        chk("set_done",     32'(obs_done), 32'd1);
        chk("set_err",      32'(obs_err),  32'd0);
        chk("set_op_cnt",   32'(op_cnt),   32'd1);

        // Reset request with qn_fb already 0: completes without driving
        force_qn(1'b0);
        step();
        clear_obs();
        req_valid = 1'b1; req_op = 1'b0;
        step();
        req_valid = 1'b0;
        chk("noop_done_next", 32'(done), 32'd1);
        repeat (5) step();
        chk("noop_drives", 32'(obs_s + obs_r), 32'd0);
        chk("noop_done",   32'(obs_done),      32'd1);
        chk("noop_op_cnt", 32'(op_cnt),        32'd2);

        // Set with a stuck flop
        clear_obs();
        p_stuck = 1'b1;
        req_valid = 1'b1; req_op = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (12) step();
        chk("stuck_err",    32'(obs_err),  VERIFY ? 32'd1 : 32'd0);
        chk("stuck_done",   32'(obs_done), VERIFY ? 32'd0 : 32'd1);
        chk("stuck_op_cnt", 32'(op_cnt),   VERIFY ? 32'd2 : 32'd3);

        // Reset in the second drive cycle aborts the operation
        force_qn(1'b0);
        clear_obs();
        p_stuck = 1'b0; p_lat = 5;
        req_valid = 1'b1; req_op = 1'b1;
        step();
        req_valid = 1'b0;
        chk("abort_s_drive1", 32'(s), 32'd1);
        step();
        rst = 1'b1;
        step();
        chk("abort_s_dropped", 32'(s), 32'd0);
        rst = 1'b0;
        step();
        chk("abort_ready", 32'(req_ready), 32'd1);
        repeat (8) step();
        chk("abort_op_cnt",      32'(op_cnt),            32'd0);
        chk("abort_no_done_err", 32'(obs_done + obs_err), 32'd0);

        // 256 back-to-back alternating operations wrap the counter
        force_qn(1'b0);
        p_lat = 0; p_stuck = 1'b0;
        clear_obs();
        accepted = 0; guard = 0; nxt = 1'b1;
        while (accepted < 256 && guard < 8000) begin
            bit was_ready;
            req_valid = 1'b1;
            req_op    = nxt;
            was_ready = (req_ready === 1'b1);
            step();
            guard++;
            if (was_ready) begin
                accepted++;
                nxt = ~nxt;
            end
        end
        req_valid = 1'b0;
        repeat (12) step();
        chk("b2b_accepted", 32'(accepted), 32'd256);
        chk("b2b_op_cnt",   32'(op_cnt),   32'd0);
        chk("b2b_done",     32'(obs_done), 32'd256);
        chk("b2b_both",     32'(obs_both), 32'd0);

        // Randomized traffic with random flop delays, stuck flops and resets
        p_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom_range(0, 2) != 0);
            req_op    = 1'($urandom_range(0, 1));
            rst       = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0; req_valid = 1'b0;
        repeat (20) step();
        chk("rand_both", 32'(obs_both), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_sr_drive_ctrl
`default_nettype wire

// File: doc/sr_drive_ctrl.md
SR_DRIVE_CTRL -- requirements
Module: sr_drive_ctrl

Interface
REQ-001 SHALL have parameter PULSE_W, default 2, cycles s/r held asserted per operation (legal 1..15).
REQ-002 SHALL have parameter TIMEOUT, default 4, maximum cycles waiting for qn_fb to match the target after the pulse (legal 1..15).
REQ-003 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, requester has an operation pending.
REQ-006 SHALL have port req_op, input, 1, requested operation: 1 = set, 0 = reset.
REQ-007 SHALL have port req_ready, output, 1, block can accept a request this cycle.
REQ-008 SHALL have port qn_fb, input, 1, state fed back from the downstream SR flop output qn.
REQ-009 SHALL have port s, output, 1, set drive to the downstream SR flop.
REQ-010 SHALL have port r, output, 1, reset drive to the downstream SR flop.
REQ-011 SHALL have port done, output, 1, one-cycle pulse on successful completion.
REQ-012 SHALL have port err, output, 1, one-cycle pulse on verify timeout.
REQ-013 SHALL have port op_cnt, output, 8, count of successfully completed operations.

Function
REQ-014 SHALL implement FSM states IDLE, DRIVE, CHECK; req_ready = 1 only in IDLE.
REQ-015 SHALL accept a request when req_valid & req_ready, latching req_op as target.
REQ-016 SHALL, on accept with qn_fb already equal to target, stay in IDLE, keep s = r = 0, pulse done next cycle, and increment op_cnt (no-op completion).
REQ-017 SHALL otherwise go to DRIVE; s (target 1) or r (target 0) asserted from the cycle after accept for exactly PULSE_W cycles.
REQ-018 SHALL never assert s and r in the same cycle; both are 0 outside DRIVE.
REQ-019 SHALL after DRIVE enter CHECK; first cycle with qn_fb == target -> done pulse, op_cnt + 1, return to IDLE.
REQ-020 SHALL, if qn_fb never matches within TIMEOUT CHECK cycles, pulse err, leave op_cnt unchanged, return to IDLE.
REQ-021 SHALL wrap op_cnt modulo 256 (255 -> 0), no saturation.
REQ-022 SHALL ignore req_valid and req_op changes outside IDLE; done and err are never both 1.
REQ-023 SHALL allow a new accept in the cycle IDLE is re-entered (back-to-back operations).

Reset
REQ-024 SHALL, while rst = 1 at a clock edge, force IDLE, s = r = 0, done = err = 0, op_cnt = 0, counters = 0; req_ready = 1 from the first cycle after rst deasserts.
REQ-025 SHALL abort any operation mid-DRIVE or mid-CHECK on reset, with no done/err pulse.

Configuration
REQ-026 SHALL use macro SR_DRIVE_VERIFY_EN: defined -> CHECK state and err behave as REQ-019/020.
REQ-027 SHALL, without SR_DRIVE_VERIFY_EN, omit CHECK: DRIVE returns to IDLE with done pulse and op_cnt + 1 in the cycle after the last drive cycle; err tied 0; qn_fb used only for REQ-016.

Structure
REQ-028 SHALL place state enum (IDLE, DRIVE, CHECK), op encodings (OP_SET = 1, OP_RST = 0) and 4-bit cycle-counter width in shared package sr_drive_pkg.
REQ-029 SHALL use one sub-module, sr_pulse_timer: loadable 4-bit down-counter with expiry flag, shared by DRIVE and CHECK.

Verification
REQ-030 Reset then set with qn_fb = 0, PULSE_W = 2, qn_fb -> 1 after 1 cycle -> s high 2 cycles, r = 0, done once, op_cnt = 1.
REQ-031 Request reset with qn_fb already 0 -> s = r = 0 throughout, done next cycle, op_cnt + 1.
REQ-032 Set with qn_fb held 0, TIMEOUT = 4, macro defined -> err after 4 CHECK cycles, no done, op_cnt unchanged; macro undefined -> done, err = 0.
REQ-033 rst asserted in second DRIVE cycle -> s drops next edge, no done/err, op_cnt = 0, req_ready = 1 after release.
REQ-034 256 back-to-back successful alternating set/reset requests -> op_cnt wraps to 0, s & r never both 1, req_ready low during every operation.
